// File: rtl/q_add8_stream_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | q_add8_pkg: shared types and constants for the q_add8_stream controller.  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
package q_add8_pkg;

  localparam int Q_ADD8_DELAY_DEFAULT = 8;
  localparam int Q_ADD8_DATA_W        = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } q_add8_state_e;

endpackage : q_add8_pkg
`default_nettype wire

// File: rtl/q_add8_stream_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | q_add8_stream_if: job control, operand SRAM, adder and result ports.     |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
interface q_add8_stream_if
  import q_add8_pkg::*;
#(
  parameter int ADDR_W = 12
);

  logic                     START;
  logic [ADDR_W:0]          LEN;
  logic [ADDR_W-1:0]        A_BASE;
  logic [ADDR_W-1:0]        B_BASE;
  logic [ADDR_W-1:0]        C_BASE;
  logic                     PAUSE;
  logic                     BUSY;
  logic                     DONE;
  logic                     ERR;

  logic                     A_RD_EN;
  logic                     B_RD_EN;
  logic [ADDR_W-1:0]        A_RD_ADDR;
  logic [ADDR_W-1:0]        B_RD_ADDR;
  logic [Q_ADD8_DATA_W-1:0] A_RD_DATA;
  logic [Q_ADD8_DATA_W-1:0] B_RD_DATA;

  logic                     ADD_EN;
  logic [Q_ADD8_DATA_W-1:0] ADD_A;
  logic [Q_ADD8_DATA_W-1:0] ADD_B;
  logic                     ADD_EN_OUT;
  logic [Q_ADD8_DATA_W-1:0] ADD_C;

  logic                     C_WR_EN;
  logic [ADDR_W-1:0]        C_WR_ADDR;
  logic [Q_ADD8_DATA_W-1:0] C_WR_DATA;

  logic [Q_ADD8_DATA_W-1:0] RES_MIN;
  logic [Q_ADD8_DATA_W-1:0] RES_MAX;

  // Environment side: sequencer, SRAMs and adder.
  modport master (
    output START, LEN, A_BASE, B_BASE, C_BASE, PAUSE,
    output A_RD_DATA, B_RD_DATA, ADD_EN_OUT, ADD_C,
    input  BUSY, DONE, ERR, A_RD_EN, B_RD_EN, A_RD_ADDR, B_RD_ADDR,
    input  ADD_EN, ADD_A, ADD_B, C_WR_EN, C_WR_ADDR, C_WR_DATA, RES_MIN, RES_MAX
  );

  // Streaming controller side.
  modport slave (
    input  START, LEN, A_BASE, B_BASE, C_BASE, PAUSE,
    input  A_RD_DATA, B_RD_DATA, ADD_EN_OUT, ADD_C,
    output BUSY, DONE, ERR, A_RD_EN, B_RD_EN, A_RD_ADDR, B_RD_ADDR,
    output ADD_EN, ADD_A, ADD_B, C_WR_EN, C_WR_ADDR, C_WR_DATA, RES_MIN, RES_MAX
  );

endinterface : q_add8_stream_if
`default_nettype wire

// File: rtl/q_add8_stream_minmax.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | q_add8_minmax: unsigned min/max of written results (Q_ADD8_STREAM_MINMAX_EN). |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`ifdef Q_ADD8_STREAM_MINMAX_EN
module q_add8_minmax
  import q_add8_pkg::*;
(
  input  wire logic                     clk,
  input  wire logic                     rst,
  input  wire logic                     clear_i,
  input  wire logic                     wr_en_i,
  input  wire logic [Q_ADD8_DATA_W-1:0] wr_data_i,
  output logic      [Q_ADD8_DATA_W-1:0] min_o,
  output logic      [Q_ADD8_DATA_W-1:0] max_o
);

  logic [Q_ADD8_DATA_W-1:0] min_q, min_d;
  logic [Q_ADD8_DATA_W-1:0] max_q, max_d;

  always_comb begin
    min_d = min_q;
    max_d = max_q;
    if (clear_i) begin
      min_d = '1;
      max_d = '0;
    end else if (wr_en_i) begin
      if (wr_data_i < min_q) min_d = wr_data_i;
      if (wr_data_i > max_q) max_d = wr_data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      min_q <= '1;
      max_q <= '0;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
    end
  end

  assign min_o = min_q;
  assign max_o = max_q;

endmodule : q_add8_minmax
`endif
`default_nettype wire

// File: rtl/q_add8_stream.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | q_add8_stream: streams SRAM operand pairs through the 8-bit adder and     |
// | writes results back. Q_ADD8_STREAM_MINMAX_EN adds result range tracking.  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module q_add8_stream
  import q_add8_pkg::*;
#(
  parameter int ADDR_W    = 12,
  parameter int ADD_DELAY = Q_ADD8_DELAY_DEFAULT
) (
  input wire logic       CLK,
  input wire logic       RESET_X,
  q_add8_stream_if.slave bus
);

  if (ADD_DELAY < 1) begin : g_bad_add_delay
    $error("q_add8_stream: ADD_DELAY must be at least 1");
  end

  q_add8_state_e            state_q, state_d;
  logic [ADDR_W:0]          len_q, len_d;
  logic [ADDR_W:0]          iss_q, iss_d;
  logic [ADDR_W:0]          acc_q, acc_d;
  logic [ADDR_W-1:0]        a_base_q, a_base_d;
  logic [ADDR_W-1:0]        b_base_q, b_base_d;
  logic [ADDR_W-1:0]        c_base_q, c_base_d;
  logic                     rd_dly_q, rd_dly_d;
  logic                     add_en_q, add_en_d;
  logic [Q_ADD8_DATA_W-1:0] add_a_q, add_a_d;
  logic [Q_ADD8_DATA_W-1:0] add_b_q, add_b_d;
  logic                     wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]        wr_addr_q, wr_addr_d;
  logic [Q_ADD8_DATA_W-1:0] wr_data_q, wr_data_d;
  logic                     err_q, err_d;

  logic w_start_acc;
  logic w_rd_en;
  logic w_stray;
  logic w_accept;

  assign w_start_acc = bus.START && (state_q == ST_IDLE);
  assign w_rd_en     = (state_q == ST_ISSUE) && !bus.PAUSE;
  // Results are counted when they arrive; a result with nothing outstanding is stray.
  assign w_stray     = bus.ADD_EN_OUT && (iss_q == acc_q);
  assign w_accept    = bus.ADD_EN_OUT && !w_stray;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (w_start_acc) state_d = (bus.LEN == '0) ? ST_DONE : ST_ISSUE;
      ST_ISSUE: if (w_rd_en && ((iss_q + 1'b1) == len_q)) state_d = ST_DRAIN;
      ST_DRAIN: if (wr_en_q && (acc_q == len_q)) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    len_d    = len_q;
    a_base_d = a_base_q;
    b_base_d = b_base_q;
    c_base_d = c_base_q;
    iss_d    = iss_q;
    acc_d    = acc_q;
    err_d    = err_q;
    if (w_start_acc) begin
      len_d    = bus.LEN;
      a_base_d = bus.A_BASE;
      b_base_d = bus.B_BASE;
      c_base_d = bus.C_BASE;
      iss_d    = '0;
      acc_d    = '0;
      err_d    = 1'b0;
    end else begin
      if (w_rd_en)  iss_d = iss_q + 1'b1;
      if (w_accept) acc_d = acc_q + 1'b1;
    end
    if (w_stray) err_d = 1'b1;

    rd_dly_d  = w_rd_en;
    add_en_d  = rd_dly_q;
    add_a_d   = rd_dly_q ? bus.A_RD_DATA : '0;
    add_b_d   = rd_dly_q ? bus.B_RD_DATA : '0;
    wr_en_d   = w_accept;
    wr_addr_d = w_accept ? (c_base_q + acc_q[ADDR_W-1:0]) : '0;
    wr_data_d = w_accept ? bus.ADD_C : '0;
  end

  always_ff @(posedge CLK or posedge RESET_X) begin
    if (RESET_X) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge CLK or posedge RESET_X) begin
    if (RESET_X) begin
      len_q     <= '0;
      a_base_q  <= '0;
      b_base_q  <= '0;
      c_base_q  <= '0;
      iss_q     <= '0;
      acc_q     <= '0;
      err_q     <= 1'b0;
      rd_dly_q  <= 1'b0;
      add_en_q  <= 1'b0;
      add_a_q   <= '0;
      add_b_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      len_q     <= len_d;
      a_base_q  <= a_base_d;
      b_base_q  <= b_base_d;
      c_base_q  <= c_base_d;
      iss_q     <= iss_d;
      acc_q     <= acc_d;
      err_q     <= err_d;
      rd_dly_q  <= rd_dly_d;
      add_en_q  <= add_en_d;
      add_a_q   <= add_a_d;
      add_b_q   <= add_b_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign bus.BUSY      = (state_q != ST_IDLE);
  assign bus.DONE      = (state_q == ST_DONE);
  assign bus.ERR       = err_q;
  assign bus.A_RD_EN   = w_rd_en;
  assign bus.B_RD_EN   = w_rd_en;
  assign bus.A_RD_ADDR = w_rd_en ? (a_base_q + iss_q[ADDR_W-1:0]) : '0;
  assign bus.B_RD_ADDR = w_rd_en ? (b_base_q + iss_q[ADDR_W-1:0]) : '0;
  assign bus.ADD_EN    = add_en_q;
  assign bus.ADD_A     = add_a_q;
  assign bus.ADD_B     = add_b_q;
  assign bus.C_WR_EN   = wr_en_q;
  assign bus.C_WR_ADDR = wr_addr_q;
  assign bus.C_WR_DATA = wr_data_q;

`ifdef Q_ADD8_STREAM_MINMAX_EN
  q_add8_minmax u_minmax (
    .clk       (CLK),
    .rst       (RESET_X),
    .clear_i   (w_start_acc),
    .wr_en_i   (wr_en_q),
    .wr_data_i (wr_data_q),
    .min_o     (bus.RES_MIN),
    .max_o     (bus.RES_MAX)
  );
`else
  assign bus.RES_MIN = 8'hFF;
  assign bus.RES_MAX = 8'h00;
`endif

endmodule : q_add8_stream
`default_nettype wire

// File: doc/q_add8_stream.md
# q_add8_stream

Job-level streaming controller on the sending side of the 8-bit quantized-add datapath. It reads operand pairs from two operand SRAMs and drives them into the adder's `INPUT_EN`/`A_IN`/`B_IN` interface. It collects the delayed `OUTPUT_EN`/`C_OUT` results and writes them back to a result SRAM. The NPU sequencer launches one vector add per `START` pulse and waits for `DONE`.

## Interface
- `ADDR_W`, default 12: SRAM address width. The maximum job length is 2^ADDR_W elements.
- `ADD_DELAY`, default 8: adder latency, from `INPUT_EN` to `OUTPUT_EN`, in cycles.
- `CLK` in 1: single clock. All logic is rising-edge.
- `RESET_X` in 1: asynchronous, active-high reset.
- `START` in 1: single-cycle job launch. It is ignored while `BUSY`=1.
- `LEN` in ADDR_W+1: element count, sampled on `START`.
- `A_BASE`, `B_BASE`, `C_BASE` in ADDR_W each: base addresses, sampled on `START`.
- `PAUSE` in 1: while 1, no new reads are issued. Results still in flight keep draining.
- `BUSY` out 1: high from the cycle after an accepted `START` until the `DONE` cycle, inclusive.
- `DONE` out 1: one-cycle pulse when the job completes.
- `ERR` out 1: sticky flag for an unexpected result. Cleared by an accepted `START`.
- `A_RD_EN`, `B_RD_EN` out 1; `A_RD_ADDR`, `B_RD_ADDR` out ADDR_W: operand read ports.
- `A_RD_DATA`, `B_RD_DATA` in 8: operand read data, valid 1 cycle after the read enable.
- `ADD_EN`, `ADD_A`, `ADD_B` out 1/8/8: drive the adder's `INPUT_EN`, `A_IN`, `B_IN`.
- `ADD_EN_OUT`, `ADD_C` in 1/8: connect from the adder's `OUTPUT_EN` and `C_OUT`.
- `C_WR_EN` out 1, `C_WR_ADDR` out ADDR_W, `C_WR_DATA` out 8: result write port, which always accepts.
- `RES_MIN`, `RES_MAX` out 8: result range. Only meaningful when the macro is defined; see Configuration.

## Operation
- FSM states and transitions:
  - IDLE -> ISSUE on an accepted `START` with `LEN`≠0.
  - IDLE -> DONE on an accepted `START` with `LEN`=0.
  - ISSUE -> DRAIN after `LEN` reads have been issued.
  - DRAIN -> DONE when `LEN` results have been written.
  - DONE -> IDLE unconditionally.
- ISSUE, per cycle with `PAUSE`=0:
  - Assert `A_RD_EN` and `B_RD_EN` at `A_BASE+i` and `B_BASE+i`.
  - Increment the issue count `i`.
- Operand path, registered:
  - `ADD_EN` is the read enable delayed by 2 cycles.
  - `ADD_A`/`ADD_B` are `A_RD_DATA`/`B_RD_DATA` registered once.
  - `ADD_A`/`ADD_B` hold 0 when `ADD_EN`=0.
- Result path, registered:
  - On `ADD_EN_OUT`=1, the next cycle drives `C_WR_EN`=1, `C_WR_ADDR`=`C_BASE+r`, `C_WR_DATA`=`ADD_C`.
  - The result count `r` then increments.
- Address arithmetic is modulo 2^ADDR_W; base+offset wraps silently.
- Outstanding count = issued − written. An `ADD_EN_OUT` arriving when the outstanding count is 0 (including in IDLE or DONE):
  - sets `ERR`;
  - produces no write;
  - does not change the counters.
- `START` while `BUSY`=1: ignored, with no effect on `ERR` or the latched parameters.
- `PAUSE` asserted in DRAIN or IDLE: no effect.

## Timing
- Reset values: FSM=IDLE, counters=0, `ERR`=0, `RES_MIN`=8'hFF, `RES_MAX`=8'h00. Every other output is 0.
- Reset mid-job: all state returns to reset values immediately (asynchronous). In-flight adder results arriving after reset set `ERR`; this is by design.
- Read-enable latencies:
  - `START` at cycle 0 gives the first read enable at cycle 1.
  - That read produces `ADD_EN` at cycle 3.
  - It produces `ADD_EN_OUT` at cycle 3+ADD_DELAY.
  - The write occurs at cycle 4+ADD_DELAY.
- Job latency with `PAUSE`=0: `DONE` at cycle LEN+ADD_DELAY+4. `DONE` fires the cycle after the last write.
- `LEN`=0: `DONE` at cycle 1. No reads or writes occur.
- Throughput: one element per cycle.

## Configuration
- `Q_ADD8_STREAM_MINMAX_EN` defined:
  - `RES_MIN`/`RES_MAX` track the unsigned min/max of written `C_WR_DATA`.
  - They are initialised to FF/00 on an accepted `START`.
  - They are updated in the same cycle as `C_WR_EN`, so the new value is visible the cycle after the write.
- Undefined: `RES_MIN` is tied to 8'hFF and `RES_MAX` to 8'h00, and no tracking logic is built.

## Structure
- Package `q_add8_pkg`:
  - FSM state enum (IDLE, ISSUE, DRAIN, DONE);
  - `Q_ADD8_DELAY_DEFAULT`=8;
  - the data width constant (8).
- One sub-module, `q_add8_minmax`: the min/max tracker, instantiated only under the macro.

## Test plan
- Basic job:
  - Stimulus: `LEN`=4, A=[1,2,3,4], B=[10,20,30,40], behavioural adder model C=A+B with delay 8, `C_BASE`=0x100.
  - Required response: writes 11,22,33,44 at 0x100–0x103; `DONE` at cycle 16; `BUSY` low after.
- Empty job:
  - Stimulus: `LEN`=0.
  - Required response: `DONE` at cycle 1; no `RD_EN`, `ADD_EN` or `C_WR_EN` ever asserted.
- Pause:
  - Stimulus: `LEN`=8, `PAUSE`=1 for 3 cycles after the 2nd read.
  - Required response: 8 contiguous writes; `DONE` at cycle 23.
- Wrap and reset:
  - Stimulus: `A_BASE`=0xFFE, `LEN`=4.
  - Required response: reads at 0xFFE, 0xFFF, 0x000, 0x001.
  - Then assert `RESET_X` in ISSUE: all outputs return to reset values at once, and a new `START` completes normally.
- Stray result:
  - Stimulus: `ADD_EN_OUT` pulse while IDLE.
  - Required response: `ERR`=1, no write. The next `START` clears `ERR`.
- Min/max, macro defined:
  - Stimulus: results 5, 200, 17.
  - Required response: `RES_MIN`=5, `RES_MAX`=200; the next `START` resets them to FF/00.
